// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_pkg
// Brief   : Shared widths and result-entry type for the common data bus.
// Revision: 1.0 - initial release
// ============================================================================
package cdb_pkg;

    localparam int NUM_OF_FU              = 4;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int REG_VAL_WIDTH          = 32;
    localparam int ROB_SIZE_WIDTH         = 5;
    localparam int INST_ADDR_WIDTH        = 32;
    localparam int FU_ID_WIDTH            = (NUM_OF_FU > 1) ? $clog2(NUM_OF_FU) : 1;

    typedef struct packed {
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] reg_addr;
        logic [REG_VAL_WIDTH-1:0]          reg_val;
        logic [ROB_SIZE_WIDTH-1:0]         tag;
        logic [INST_ADDR_WIDTH-1:0]        pc;
        logic                              branch_taken;
    } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first set request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && i_req[IDX_WIDTH'(w_j)]) begin
                w_found                    = 1'b1;
                o_grant[IDX_WIDTH'(w_j)]   = 1'b1;
                o_idx                      = IDX_WIDTH'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : One holding entry per FU, round-robin broadcast onto the CDB.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_OF_FU-1:0]              fu_valid,
    output logic [NUM_OF_FU-1:0]              fu_ready,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] fu_reg_addr     [NUM_OF_FU],
    input  logic [REG_VAL_WIDTH-1:0]          fu_reg_val      [NUM_OF_FU],
    input  logic [ROB_SIZE_WIDTH-1:0]         fu_tag          [NUM_OF_FU],
    input  logic [INST_ADDR_WIDTH-1:0]        fu_pc           [NUM_OF_FU],
    input  logic                              fu_branch_taken [NUM_OF_FU],
    output logic                              cdb_valid,
    input  logic                              cdb_ready,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_reg_addr,
    output logic [REG_VAL_WIDTH-1:0]          cdb_reg_val,
    output logic [ROB_SIZE_WIDTH-1:0]         cdb_tag,
    output logic [INST_ADDR_WIDTH-1:0]        cdb_pc,
    output logic                              cdb_branch_taken,
    output logic [FU_ID_WIDTH-1:0]            cdb_fu_id
);

    cdb_entry_t             r_entry [NUM_OF_FU];
    logic [NUM_OF_FU-1:0]   r_valid;
    logic                   r_lock;
    logic [FU_ID_WIDTH-1:0] r_lock_idx;
    logic [FU_ID_WIDTH-1:0] r_rr_ptr;

    logic [NUM_OF_FU-1:0]   w_grant;
    logic [FU_ID_WIDTH-1:0] w_arb_idx;
    logic [FU_ID_WIDTH-1:0] w_sel_idx;
    logic [FU_ID_WIDTH-1:0] w_next_ptr;
    logic                   w_any;
    logic                   w_xfer;
    logic [NUM_OF_FU-1:0]   w_drain;
    cdb_entry_t             w_sel_entry;

    rr_arbiter #(
        .NUM_REQ   (NUM_OF_FU),
        .IDX_WIDTH (FU_ID_WIDTH)
    ) u_rr_arbiter (
        .i_req   (r_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_arb_idx)
    );

    // A stalled broadcast keeps its index so a newly filled entry cannot cut in.
    assign w_sel_idx   = r_lock ? r_lock_idx : w_arb_idx;
    assign w_any       = |r_valid;
    assign cdb_valid   = w_any & ~flush;
    assign w_xfer      = cdb_valid & cdb_ready;
    assign w_sel_entry = w_any ? r_entry[w_sel_idx] : '0;
    assign w_next_ptr  = (w_sel_idx == FU_ID_WIDTH'(NUM_OF_FU - 1)) ? '0
                                                                    : w_sel_idx + FU_ID_WIDTH'(1);

    assign cdb_reg_addr     = w_sel_entry.reg_addr;
    assign cdb_reg_val      = w_sel_entry.reg_val;
    assign cdb_tag          = w_sel_entry.tag;
    assign cdb_pc           = w_sel_entry.pc;
    assign cdb_branch_taken = w_sel_entry.branch_taken;
    assign cdb_fu_id        = w_any ? w_sel_idx : '0;

    always_comb begin
        w_drain  = '0;
        fu_ready = '0;
        for (int i = 0; i < NUM_OF_FU; i++) begin
            w_drain[i]  = w_xfer && (w_sel_idx == FU_ID_WIDTH'(i));
            fu_ready[i] = (~r_valid[i] | w_drain[i]) & ~flush & rst_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_lock  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OF_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_xfer) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_next_ptr;
            end else if (cdb_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel_idx;
            end
        end
    end

    // Payload needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OF_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                r_entry[i].reg_addr     <= fu_reg_addr[i];
                r_entry[i].reg_val      <= fu_reg_val[i];
                r_entry[i].tag          <= fu_tag[i];
                r_entry[i].pc           <= fu_pc[i];
                r_entry[i].branch_taken <= fu_branch_taken[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed self-checking bench for cdb_arbiter (four FUs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              flush;
    logic [NUM_OF_FU-1:0]              fu_valid;
    logic [NUM_OF_FU-1:0]              fu_ready;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] fu_reg_addr     [NUM_OF_FU];
    logic [REG_VAL_WIDTH-1:0]          fu_reg_val      [NUM_OF_FU];
    logic [ROB_SIZE_WIDTH-1:0]         fu_tag          [NUM_OF_FU];
    logic [INST_ADDR_WIDTH-1:0]        fu_pc           [NUM_OF_FU];
    logic                              fu_branch_taken [NUM_OF_FU];
    logic                              cdb_valid;
    logic                              cdb_ready;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_reg_addr;
    logic [REG_VAL_WIDTH-1:0]          cdb_reg_val;
    logic [ROB_SIZE_WIDTH-1:0]         cdb_tag;
    logic [INST_ADDR_WIDTH-1:0]        cdb_pc;
    logic                              cdb_branch_taken;
    logic [FU_ID_WIDTH-1:0]            cdb_fu_id;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .fu_valid         (fu_valid),
        .fu_ready         (fu_ready),
        .fu_reg_addr      (fu_reg_addr),
        .fu_reg_val       (fu_reg_val),
        .fu_tag           (fu_tag),
        .fu_pc            (fu_pc),
        .fu_branch_taken  (fu_branch_taken),
        .cdb_valid        (cdb_valid),
        .cdb_ready        (cdb_ready),
        .cdb_reg_addr     (cdb_reg_addr),
        .cdb_reg_val      (cdb_reg_val),
        .cdb_tag          (cdb_tag),
        .cdb_pc           (cdb_pc),
        .cdb_branch_taken (cdb_branch_taken),
        .cdb_fu_id        (cdb_fu_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        fu_valid  = '0;
        for (int i = 0; i < NUM_OF_FU; i++) begin
            fu_reg_addr[i]     = PHYSICAL_REG_NUM_WIDTH'(i + 1);
            fu_reg_val[i]      = 32'h100 + 32'(i);
            fu_tag[i]          = '0;
            fu_pc[i]           = 32'h1000 + 32'(i * 4);
            fu_branch_taken[i] = 1'b0;
        end

        // Reset state
        #2;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_fu_ready",  32'(fu_ready),  32'h0);
        chk("rst_cdb_tag",   32'(cdb_tag),   32'd0);
        chk("rst_cdb_val",   cdb_reg_val,    32'd0);
        chk("rst_cdb_fu_id", 32'(cdb_fu_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fu_ready", 32'(fu_ready), 32'hf);

        // Single request from FU2
        fu_valid[2] = 1'b1;
        fu_tag[2]   = 5'd5;
        #1;
        chk("single_ready2", 32'(fu_ready[2]), 32'd1);
        tick();
        fu_valid = '0;
        #1;
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag",   32'(cdb_tag),   32'd5);
        chk("single_fu_id", 32'(cdb_fu_id), 32'd2);
        chk("single_val",   cdb_reg_val,    32'h102);
        tick();
        chk("single_done_valid", 32'(cdb_valid), 32'd0);
        chk("single_rr_ptr", 32'(dut.r_rr_ptr), 32'd3);
        chk("idle_payload_zero", cdb_pc, 32'd0);

        // Fairness with all FUs permanently valid
        do_reset();
        for (int i = 0; i < NUM_OF_FU; i++) fu_tag[i] = ROB_SIZE_WIDTH'(8 + i);
        fu_valid = 4'hf;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("fair_valid", 32'(cdb_valid), 32'd1);
            chk("fair_fu_id", 32'(cdb_fu_id), 32'(c % 4));
            chk("fair_tag",   32'(cdb_tag),   32'(8 + c % 4));
            tick();
        end
        fu_valid = '0;

        // Backpressure and lock
        do_reset();
        cdb_ready   = 1'b0;
        fu_valid[1] = 1'b1;
        fu_tag[1]   = 5'd7;
        tick();
        fu_valid[1] = 1'b0;
        fu_valid[0] = 1'b1;
        fu_tag[0]   = 5'd3;
        #1;
        chk("bp_fu_id0",  32'(cdb_fu_id),   32'd1);
        chk("bp_ready0",  32'(fu_ready[0]), 32'd1);
        chk("bp_ready1",  32'(fu_ready[1]), 32'd0);
        tick();
        fu_valid[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_lock_fu_id",  32'(cdb_fu_id),   32'd1);
            chk("bp_lock_tag",    32'(cdb_tag),     32'd7);
            chk("bp_lock_val",    cdb_reg_val,      32'h101);
            chk("bp_lock_ready0", 32'(fu_ready[0]), 32'd0);
            chk("bp_lock_ready1", 32'(fu_ready[1]), 32'd0);
            tick();
        end
        cdb_ready = 1'b1;
        #1;
        chk("bp_rel_fu_id",  32'(cdb_fu_id),   32'd1);
        chk("bp_rel_ready1", 32'(fu_ready[1]), 32'd1);
        tick();
        chk("bp_second_valid", 32'(cdb_valid), 32'd1);
        chk("bp_second_fu_id", 32'(cdb_fu_id), 32'd0);
        chk("bp_second_tag",   32'(cdb_tag),   32'd3);
        tick();
        chk("bp_drained", 32'(cdb_valid), 32'd0);

        // Same-cycle refill stream from FU3
        do_reset();
        fu_valid[3] = 1'b1;
        fu_tag[3]   = 5'd10;
        tick();
        for (int k = 0; k < 4; k++) begin
            fu_tag[3] = ROB_SIZE_WIDTH'(11 + k);
            #1;
            chk("refill_fu_id",  32'(cdb_fu_id),   32'd3);
            chk("refill_tag",    32'(cdb_tag),     32'(10 + k));
            chk("refill_ready3", 32'(fu_ready[3]), 32'd1);
            tick();
        end
        fu_valid = '0;
        #1;
        chk("refill_last_tag", 32'(cdb_tag), 32'd14);
        tick();
        chk("refill_empty", 32'(cdb_valid), 32'd0);

        // Flush with entries 0 and 2 full, rr_ptr moved to 2 first
        do_reset();
        fu_valid[1] = 1'b1;
        fu_tag[1]   = 5'd1;
        tick();
        fu_valid = '0;
        tick();
        chk("flush_pre_ptr", 32'(dut.r_rr_ptr), 32'd2);
        cdb_ready = 1'b0;
        fu_valid  = 4'b0101;
        fu_tag[0] = 5'd20;
        fu_tag[2] = 5'd22;
        tick();
        fu_valid = '0;
        #1;
        chk("flush_sel", 32'(cdb_fu_id), 32'd2);
        flush     = 1'b1;
        cdb_ready = 1'b1;
        #1;
        chk("flush_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("flush_fu_ready",  32'(fu_ready),  32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_after_valid", 32'(cdb_valid),     32'd0);
        chk("flush_after_ptr",   32'(dut.r_rr_ptr),  32'd2);
        chk("flush_after_ready", 32'(fu_ready),      32'hf);

        // Asynchronous reset in the middle of a stall
        cdb_ready   = 1'b0;
        fu_valid[1] = 1'b1;
        fu_tag[1]   = 5'd9;
        tick();
        fu_valid = '0;
        chk("arst_stall_valid", 32'(cdb_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_drop", 32'(cdb_valid), 32'd0);
        chk("arst_ready_drop", 32'(fu_ready),  32'h0);
        chk("arst_tag_zero",   32'(cdb_tag),   32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        cdb_ready   = 1'b1;
        fu_valid[2] = 1'b1;
        fu_tag[2]   = 5'd4;
        tick();
        fu_valid = '0;
        #1;
        chk("arst_new_valid", 32'(cdb_valid), 32'd1);
        chk("arst_new_fu_id", 32'(cdb_fu_id), 32'd2);
        chk("arst_new_tag",   32'(cdb_tag),   32'd4);
        tick();
        chk("arst_new_done", 32'(cdb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
